// File: rtl/i2c_tgt_sync.sv
// Clock-oversampled I2C target answering a single 7-bit address on an open-drain bus.
// Optional clock stretching on transmit underrun is enabled by defining I2C_TGT_STRETCH_EN.
module i2c_tgt_sync #(
  parameter logic [6:0]  ADDR        = 7'h3b,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  input  logic [7:0] tx_dat,
  input  logic       tx_vld,
  output logic       tx_req,
  output logic       rd,
  output logic       busy,
  output logic       stop
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StIgnore, StAack, StRx, StRack, StTx, StTack, StLoad, StStretch
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_p_q, sda_p_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_c, stop_c;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, shifted;
  logic       sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
  logic [7:0] rx_dat_q, rx_dat_d;
  logic       rx_vld_q, rx_vld_d, tx_req_q, tx_req_d;
  logic       rd_q, rd_d, busy_q, busy_d, stop_q, stop_d;
  logic       load;
  logic       unused_tx_vld;

  assign unused_tx_vld = tx_vld;

  // Synchronizers reset to the idle-high bus level so no false edge follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_p_q    <= scl_s;
      sda_p_q    <= sda_s;
    end
  end

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_p_q;
  assign scl_fall = ~scl_s & scl_p_q;
  assign start_c  = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop_c   = scl_s & scl_p_q & ~sda_p_q & sda_s;
  assign shifted  = {sh_q[6:0], sda_s};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    sda_oe_d = sda_oe_q;
    scl_oe_d = 1'b0;
    rx_dat_d = rx_dat_q;
    rx_vld_d = 1'b0;
    tx_req_d = 1'b0;
    rd_d     = rd_q;
    busy_d   = busy_q;
    stop_d   = 1'b0;
    load     = 1'b0;

    unique case (state_q)
      StAddr: begin
        if (scl_rise) begin
          sh_d  = shifted;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (shifted[7:1] == ADDR) begin
              rd_d     = shifted[0];
              tx_req_d = shifted[0];
              state_d  = StAack;
            end else begin
              state_d = StIgnore;
            end
          end
        end
      end
      // First falling edge asserts the ACK, the second ends it.
      StAack: begin
        if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
            busy_d   = 1'b1;
          end else if (rd_q) begin
            load = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = StRx;
          end
        end
      end
      StRx: begin
        if (scl_rise) begin
          sh_d  = shifted;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_dat_d = shifted;
            rx_vld_d = 1'b1;
            state_d  = StRack;
          end
        end
      end
      StRack: begin
        if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = StRx;
          end
        end
      end
      // Counter wraps to 0 on the 8th rising edge, so a falling edge at 0 ends the byte.
      StTx: begin
        if (scl_rise) begin
          cnt_d = cnt_q + 3'd1;
        end else if (scl_fall) begin
          if (cnt_q == 3'd0) begin
            sda_oe_d = 1'b0;
            state_d  = StTack;
          end else begin
            sh_d     = {sh_q[6:0], 1'b0};
            sda_oe_d = ~sh_q[6];
          end
        end
      end
      StTack: begin
        if (scl_rise) begin
          if (!sda_s) begin
            tx_req_d = 1'b1;
            state_d  = StLoad;
          end else begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = StIgnore;
          end
        end
      end
      StLoad: begin
        if (scl_fall) load = 1'b1;
      end
`ifdef I2C_TGT_STRETCH_EN
      // scl_oe stays set through the latch clk and drops one clk later in StTx.
      StStretch: begin
        scl_oe_d = 1'b1;
        if (tx_vld) begin
          sh_d     = tx_dat;
          sda_oe_d = ~tx_dat[7];
          state_d  = StTx;
        end
      end
`endif
      default: ;
    endcase

    if (load) begin
      sh_d     = tx_dat;
      sda_oe_d = ~tx_dat[7];
      state_d  = StTx;
`ifdef I2C_TGT_STRETCH_EN
      if (!tx_vld) begin
        sh_d     = sh_q;
        sda_oe_d = 1'b0;
        scl_oe_d = 1'b1;
        state_d  = StStretch;
      end
`endif
    end

    if (start_c) begin
      state_d  = StAddr;
      cnt_d    = 3'd0;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      busy_d   = 1'b0;
      rx_vld_d = 1'b0;
      tx_req_d = 1'b0;
    end else if (stop_c) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      scl_oe_d = 1'b0;
      busy_d   = 1'b0;
      stop_d   = busy_q;
      rx_vld_d = 1'b0;
      tx_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      sh_q     <= 8'h00;
      sda_oe_q <= 1'b0;
      scl_oe_q <= 1'b0;
      rx_dat_q <= 8'h00;
      rx_vld_q <= 1'b0;
      tx_req_q <= 1'b0;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      sda_oe_q <= sda_oe_d;
      scl_oe_q <= scl_oe_d;
      rx_dat_q <= rx_dat_d;
      rx_vld_q <= rx_vld_d;
      tx_req_q <= tx_req_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      stop_q   <= stop_d;
    end
  end

  assign sda_oe = sda_oe_q;
  assign scl_oe = scl_oe_q;
  assign rx_dat = rx_dat_q;
  assign rx_vld = rx_vld_q;
  assign tx_req = tx_req_q;
  assign rd     = rd_q;
  assign busy   = busy_q;
  assign stop   = stop_q;

endmodule

// File: tb/tb_i2c_tgt_sync.sv
// Bench for i2c_tgt_sync: bit-banged I2C master, transaction-level model and per-cycle monitor.
// Define I2C_TGT_STRETCH_EN to also exercise clock stretching.
module tb_i2c_tgt_sync;

  localparam logic [6:0] TgtAddr = 7'h3b;
  localparam int         Half    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       scl_bus, sda_bus;
  logic       sda_oe, scl_oe;
  logic [7:0] rx_dat;
  logic       rx_vld;
  logic [7:0] tx_dat = 8'h00;
  logic       tx_vld = 1'b1;
  logic       tx_req, rd, busy, stop;

  int n_chk = 0;
  int n_fail = 0;

  // Transaction-level model state (written by the stimulus process only)
  logic       m_sel = 1'b0;
  int         exp_treq = 0;
  int         exp_stop = 0;
  int         mi = 0;
  logic [7:0] exp_rx[$];
  logic       stall_req = 1'b0;

  // Monitor observations (written by the monitor only)
  int         got_treq = 0;
  int         got_stop = 0;
  int         n_oe_clk = 0;
  int         n_busy_clk = 0;
  int         stretch_clks = 0;
  int         ti = 0;
  logic [7:0] prev_rx = 8'h00;

  assign scl_bus = scl_m & ~scl_oe;
  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_tgt_sync #(.ADDR(TgtAddr), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .scl_i  (scl_bus),
    .sda_i  (sda_bus),
    .sda_oe (sda_oe),
    .scl_oe (scl_oe),
    .rx_dat (rx_dat),
    .rx_vld (rx_vld),
    .tx_dat (tx_dat),
    .tx_vld (tx_vld),
    .tx_req (tx_req),
    .rd     (rd),
    .busy   (busy),
    .stop   (stop)
  );

  function automatic logic [7:0] tx_byte(input int i);
    case (i)
      0:       return 8'ha5;
      1:       return 8'h3c;
      2:       return 8'h9e;
      3:       return 8'h00;
      default: return 8'h6d;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_up();
    int t = 0;
    scl_m = 1'b1;
    while (!scl_bus && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("scl_release", {31'd0, scl_bus}, 32'd1);
  endtask

  task automatic wbit(input logic b);
    sda_m = b;
    clks(4);
    scl_up();
    clks(Half);
    scl_m = 1'b0;
    clks(4);
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1;
    clks(4);
    scl_up();
    clks(4);
    b = sda_bus;
    clks(4);
    scl_m = 1'b0;
    clks(4);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(ack);
  endtask

  task automatic m_start();
    sda_m = 1'b1;
    clks(4);
    scl_up();
    clks(Half);
    sda_m = 1'b0;
    clks(Half);
    scl_m = 1'b0;
    clks(4);
    m_sel = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd0);
  endtask

  task automatic m_stop();
    sda_m = 1'b0;
    clks(4);
    scl_up();
    clks(Half);
    sda_m = 1'b1;
    clks(Half);
    if (m_sel) exp_stop++;
    m_sel = 1'b0;
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
    chk("stop_count", got_stop, exp_stop);
  endtask

  task automatic addr_phase(input logic [6:0] a, input logic rw);
    logic ack;
    wbyte({a, rw}, ack);
    chk("addr_ack", {31'd0, ack}, (a == TgtAddr) ? 32'd0 : 32'd1);
    m_sel = (a == TgtAddr);
    if (m_sel) begin
      if (rw) exp_treq++;
      chk("rd_dir", {31'd0, rd}, {31'd0, rw});
    end
    chk("busy_after_addr", {31'd0, busy}, {31'd0, m_sel});
    chk("treq_count", got_treq, exp_treq);
  endtask

  task automatic wr_data(input logic [7:0] d);
    logic ack;
    if (m_sel) exp_rx.push_back(d);
    wbyte(d, ack);
    chk("data_ack", {31'd0, ack}, m_sel ? 32'd0 : 32'd1);
  endtask

  task automatic rd_data(input logic last, output logic [7:0] d);
    rbyte(last, d);
    chk("rd_byte", {24'd0, d}, {24'd0, tx_byte(mi)});
    mi++;
    if (!last) exp_treq++;
    else m_sel = 1'b0;
    chk("busy_after_rd", {31'd0, busy}, {31'd0, m_sel});
    chk("treq_count", got_treq, exp_treq);
  endtask

  // Per-cycle monitor, scoreboard and tx data responder
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rx = rx_dat;
      end else begin
        chk("vld_req_excl", {31'd0, rx_vld & tx_req}, 32'd0);
        if (!rx_vld) begin
          chk("rx_dat_hold", {24'd0, rx_dat}, {24'd0, prev_rx});
        end else if (exp_rx.size() == 0) begin
          chk("rx_unexpected", {31'd0, rx_vld}, 32'd0);
        end else begin
          chk("rx_dat", {24'd0, rx_dat}, {24'd0, exp_rx.pop_front()});
        end
        prev_rx = rx_dat;
        if (tx_req) begin
          got_treq++;
          tx_dat = tx_byte(ti);
          if (ti < 4) ti++;
        end
        if (stop) got_stop++;
        if (sda_oe) n_oe_clk++;
        if (busy) n_busy_clk++;
        if (scl_oe) stretch_clks++;
`ifndef I2C_TGT_STRETCH_EN
        chk("scl_oe_tied", {31'd0, scl_oe}, 32'd0);
`endif
      end
    end
  end

`ifdef I2C_TGT_STRETCH_EN
  initial begin
    int t;
    wait (stall_req);
    tx_vld = 1'b0;
    t = 0;
    while (!scl_oe && t < 2000) begin
      @(negedge clk);
      t++;
    end
    clks(20);
    tx_vld = 1'b1;
  end
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b8;
    logic       b;
    int         t0, oe0, busy0;

    rst = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    clks(3);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("rst_rx_dat", {24'd0, rx_dat}, 32'h00);
    chk("rst_rx_vld", {31'd0, rx_vld}, 32'd0);
    chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
    chk("rst_rd", {31'd0, rd}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stop", {31'd0, stop}, 32'd0);
    rst = 1'b0;
    clks(4);

    // Plain write 0x76, 0x5a
    m_start();
    addr_phase(TgtAddr, 1'b0);
    wr_data(8'h5a);
    m_stop();
    chk("t1_rx_dat", {24'd0, rx_dat}, 32'h5a);
    chk("t1_stop_once", got_stop, 1);

    // Foreign address 0x1e (byte 0x3c): target must stay off the bus
    oe0 = n_oe_clk;
    busy0 = n_busy_clk;
    m_start();
    addr_phase(7'h1e, 1'b0);
    wr_data(8'h12);
    m_stop();
    chk("t2_no_sda_oe", n_oe_clk - oe0, 0);
    chk("t2_no_busy", n_busy_clk - busy0, 0);

    // Read two bytes, ACK then NACK
    t0 = got_treq;
    m_start();
    addr_phase(TgtAddr, 1'b1);
    rd_data(1'b0, b8);
    chk("t3_byte0", {24'd0, b8}, 32'ha5);
    rd_data(1'b1, b8);
    chk("t3_byte1", {24'd0, b8}, 32'h3c);
    chk("t3_treq_twice", got_treq - t0, 2);
    chk("t3_busy_cleared", {31'd0, busy}, 32'd0);
    m_stop();

    // Write then repeated START into a one-byte read
    m_start();
    addr_phase(TgtAddr, 1'b0);
    chk("t4_rd_write", {31'd0, rd}, 32'd0);
    wr_data(8'h11);
    m_start();
    addr_phase(TgtAddr, 1'b1);
    chk("t4_rd_read", {31'd0, rd}, 32'd1);
    rd_data(1'b1, b8);
    chk("t4_byte", {24'd0, b8}, 32'h9e);
    m_stop();
    chk("t4_rx_dat", {24'd0, rx_dat}, 32'h11);

    // Reset in the middle of transmitting 0x00
    m_start();
    addr_phase(TgtAddr, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rbit(b);
      chk("t5_tx_bit", {31'd0, b}, 32'd0);
    end
    sda_m = 1'b1;
    clks(4);
    scl_up();
    clks(2);
    chk("t5_driving", {31'd0, sda_oe}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_async_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("t5_async_scl_oe", {31'd0, scl_oe}, 32'd0);
    clks(3);
    rst = 1'b0;
    m_sel = 1'b0;
    mi++;
    chk("t5_busy_rst", {31'd0, busy}, 32'd0);
    clks(Half);
    m_start();
    addr_phase(TgtAddr, 1'b0);
    wr_data(8'hc3);
    m_stop();
    chk("t5_rx_after_rst", {24'd0, rx_dat}, 32'hc3);

`ifdef I2C_TGT_STRETCH_EN
    // Stretch: tx_vld withheld for 20 clk
    stall_req = 1'b1;
    m_start();
    addr_phase(TgtAddr, 1'b1);
    rd_data(1'b1, b8);
    chk("t6_byte", {24'd0, b8}, 32'h6d);
    chk("t6_stretch_len", {31'd0, (stretch_clks >= 18 && stretch_clks <= 24)}, 32'd1);
    m_stop();
`endif

    clks(10);
    chk("rx_queue_drained", exp_rx.size(), 0);
    chk("treq_total", got_treq, exp_treq);
    chk("stop_total", got_stop, exp_stop);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
